// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 control sequencer: opcodes, state
// encoding, reset constants and small sign-extension / condition-code helpers.
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [2:0]  NZP_RESET         = 3'b010;
  localparam logic [15:0] RESET_PC_DEFAULT  = 16'h3000;
  localparam logic [7:0]  HALT_VECT_DEFAULT = 8'h25;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  // Exactly one of N/Z/P is set for any 16-bit value.
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])
      return 3'b100;
    else if (v == 16'h0000)
      return 3'b010;
    else
      return 3'b001;
  endfunction

endpackage

// File: rtl/lc3_alu.sv
// Combinational datapath for the register-writing instructions
// (ADD/AND/NOT/LEA) plus the condition codes derived from the result.
module lc3_alu
  import lc3_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [8:0]  ir_low,
  input  logic [15:0] sr1_data,
  input  logic [15:0] sr2_data,
  input  logic [15:0] pc,
  output logic [15:0] result,
  output logic [2:0]  nzp,
  output logic        writes_reg,
  output logic        sets_cc
);

  logic [15:0] operand_b;

  // Select the second operand, compute the result and flag what it updates.
  always_comb begin
    operand_b  = ir_low[5] ? sext5(ir_low[4:0]) : sr2_data;
    result     = '0;
    writes_reg = 1'b0;
    sets_cc    = 1'b0;
    case (opcode)
      OP_ADD: begin
        result     = sr1_data + operand_b;
        writes_reg = 1'b1;
        sets_cc    = 1'b1;
      end
      OP_AND: begin
        result     = sr1_data & operand_b;
        writes_reg = 1'b1;
        sets_cc    = 1'b1;
      end
      OP_NOT: begin
        result     = ~sr1_data;
        writes_reg = 1'b1;
        sets_cc    = 1'b1;
      end
      // pc is already the incremented value at this point.
      OP_LEA: begin
        result     = pc + sext9(ir_low);
        writes_reg = 1'b1;
      end
      default: ;
    endcase
    nzp = nzp_of(result);
  end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multi-cycle control sequencer: FETCH -> DECODE -> EXECUTE, owning
// PC, IR and NZP and driving the register file's selects, write strobe and data.
module lc3_ctrl_fsm
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [7:0]  HALT_VECT = HALT_VECT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Mem_Data,
  input  logic        Mem_Ready,
  output logic        Mem_Req,
  output logic [15:0] Mem_Addr,
  input  logic [15:0] SR1_Data,
  input  logic [15:0] SR2_Data,
  output logic [2:0]  SR1_Control,
  output logic [2:0]  SR2_Control,
  output logic [2:0]  DR_Control,
  output logic        Load_Reg,
  output logic [15:0] Bus_Out,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic [2:0]  NZP,
  output logic        Halted,
  output logic        Illegal
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  nzp_q, nzp_d;

  logic [3:0]  opcode;
  logic        in_exec;
  logic        is_halt_trap;
  logic        is_br;
  logic        br_taken;
  logic        illegal_op;
  logic [15:0] alu_result;
  logic [2:0]  alu_nzp;
  logic        alu_writes;
  logic        alu_sets_cc;

  assign opcode       = ir_q[15:12];
  assign in_exec      = (state_q == ST_EXECUTE);
  assign is_halt_trap = (opcode == OP_TRAP) && (ir_q[7:0] == HALT_VECT);
  assign is_br        = (opcode == OP_BR);
  assign br_taken     = is_br && (|(ir_q[11:9] & nzp_q));
  // Non-HALT TRAP vectors fall into this bucket as well.
  assign illegal_op   = !(alu_writes || is_br || is_halt_trap);

  lc3_alu u_alu (
    .opcode     (opcode),
    .ir_low     (ir_q[8:0]),
    .sr1_data   (SR1_Data),
    .sr2_data   (SR2_Data),
    .pc         (pc_q),
    .result     (alu_result),
    .nzp        (alu_nzp),
    .writes_reg (alu_writes),
    .sets_cc    (alu_sets_cc)
  );

  // Next-state, PC, IR and condition-code computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    nzp_d   = nzp_q;
    case (state_q)
      ST_FETCH: begin
        if (Mem_Ready) begin
          ir_d    = Mem_Data;
          pc_d    = pc_q + 16'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (alu_sets_cc)
          nzp_d = alu_nzp;
        if (br_taken)
          pc_d = pc_q + sext9(ir_q[8:0]);
        state_d = is_halt_trap ? ST_HALT : ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // State registers; reset overrides every other event, including a fetch in flight.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      nzp_q   <= NZP_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      nzp_q   <= nzp_d;
    end
  end

  // Register-file and memory interface outputs decoded from state and IR.
  always_comb begin
    Mem_Req     = (state_q == ST_FETCH);
    Mem_Addr    = pc_q;
    Load_Reg    = in_exec && alu_writes;
    Bus_Out     = Load_Reg ? alu_result : 16'h0000;
    DR_Control  = in_exec ? ir_q[11:9] : 3'd0;
    SR1_Control = ((state_q == ST_DECODE) || in_exec) ? ir_q[8:6] : 3'd0;
    SR2_Control = ((state_q == ST_DECODE) || in_exec) ? ir_q[2:0] : 3'd0;
    Illegal     = in_exec && illegal_op;
    Halted      = (state_q == ST_HALT);
    PC          = pc_q;
    IR          = ir_q;
    NZP         = nzp_q;
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Self-checking bench for lc3_ctrl_fsm: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
module tb_lc3_ctrl_fsm;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Mem_Data;
  logic        Mem_Ready;
  logic        Mem_Req;
  logic [15:0] Mem_Addr;
  logic [15:0] SR1_Data;
  logic [15:0] SR2_Data;
  logic [2:0]  SR1_Control;
  logic [2:0]  SR2_Control;
  logic [2:0]  DR_Control;
  logic        Load_Reg;
  logic [15:0] Bus_Out;
  logic [15:0] PC;
  logic [15:0] IR;
  logic [2:0]  NZP;
  logic        Halted;
  logic        Illegal;

  int checks = 0;
  int errors = 0;

  lc3_ctrl_fsm dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Mem_Data    (Mem_Data),
    .Mem_Ready   (Mem_Ready),
    .Mem_Req     (Mem_Req),
    .Mem_Addr    (Mem_Addr),
    .SR1_Data    (SR1_Data),
    .SR2_Data    (SR2_Data),
    .SR1_Control (SR1_Control),
    .SR2_Control (SR2_Control),
    .DR_Control  (DR_Control),
    .Load_Reg    (Load_Reg),
    .Bus_Out     (Bus_Out),
    .PC          (PC),
    .IR          (IR),
    .NZP         (NZP),
    .Halted      (Halted),
    .Illegal     (Illegal)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (architectural level) ----------------
  logic [15:0] m_pc;
  logic [2:0]  m_nzp;
  logic        m_halted;
  logic        e_load, e_ill;
  logic [2:0]  e_dr;
  logic [15:0] e_bus;
  logic [15:0] e_fetch_addr;

  task automatic model_reset();
    m_pc     = 16'h3000;
    m_nzp    = 3'b010;
    m_halted = 1'b0;
  endtask

  task automatic model_exec(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] b);
    int opc, off9, imm5, res;
    logic [15:0] opb;
    bit cc;
    opc  = int'(instr[15:12]);
    off9 = instr[8] ? int'(instr[8:0]) - 512 : int'(instr[8:0]);
    imm5 = instr[4] ? int'(instr[4:0]) - 32 : int'(instr[4:0]);
    opb  = instr[5] ? 16'(imm5) : b;
    e_fetch_addr = m_pc;
    m_pc   = 16'(int'(m_pc) + 1);
    e_load = 1'b0; e_ill = 1'b0; e_bus = 16'h0; e_dr = instr[11:9]; cc = 1'b0;
    res = 0;
    case (opc)
      1:  begin res = (int'(a) + int'(opb)) % 65536; e_load = 1'b1; cc = 1'b1; end
      5:  begin res = int'(a & opb); e_load = 1'b1; cc = 1'b1; end
      9:  begin res = 65535 - int'(a); e_load = 1'b1; cc = 1'b1; end
      14: begin res = (int'(m_pc) + off9 + 65536) % 65536; e_load = 1'b1; end
      0:  if ((instr[11:9] & m_nzp) != 3'b000) m_pc = 16'(int'(m_pc) + off9);
      15: if (instr[7:0] == 8'h25) m_halted = 1'b1; else e_ill = 1'b1;
      default: e_ill = 1'b1;
    endcase
    e_bus = 16'(res);
    if (cc) begin
      if (res >= 32768)  m_nzp = 3'b100;
      else if (res == 0) m_nzp = 3'b010;
      else               m_nzp = 3'b001;
    end
  endtask

  // ---------------- stimulus driver (observes, does not judge) ----------------
  logic        obs_addr_stable, obs_fetch_req, obs_dec_req, obs_dec_load;
  logic [15:0] obs_fetch_addr;
  logic        obs_load, obs_ill;
  logic [2:0]  obs_dr, obs_sr1c, obs_sr2c;
  logic [15:0] obs_bus;
  logic [15:0] obs_pc;
  logic [2:0]  obs_nzp;
  logic        obs_halt, obs_req, obs_ill_after, obs_load_after;
  logic [15:0] obs_bus_after;

  // Called at posedge+1 while in FETCH; returns at posedge+1 after EXECUTE.
  task automatic do_instr(input logic [15:0] instr, input logic [15:0] a,
                          input logic [15:0] b, input int waits);
    logic [15:0] first_addr;
    obs_addr_stable = 1'b1;
    first_addr = Mem_Addr;
    Mem_Ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      Mem_Data = 16'($urandom);
      if (Mem_Req !== 1'b1 || Mem_Addr !== first_addr) obs_addr_stable = 1'b0;
      @(posedge Clk); #1;
    end
    obs_fetch_addr = Mem_Addr;
    obs_fetch_req  = Mem_Req;
    if (Mem_Addr !== first_addr) obs_addr_stable = 1'b0;
    Mem_Ready = 1'b1; Mem_Data = instr; SR1_Data = a; SR2_Data = b;
    @(posedge Clk); #1;
    Mem_Ready = 1'b0; Mem_Data = 16'($urandom);
    obs_dec_req = Mem_Req; obs_dec_load = Load_Reg;
    @(posedge Clk); #1;
    obs_load = Load_Reg; obs_ill = Illegal; obs_dr = DR_Control; obs_bus = Bus_Out;
    obs_sr1c = SR1_Control; obs_sr2c = SR2_Control;
    @(posedge Clk); #1;
    obs_pc = PC; obs_nzp = NZP; obs_halt = Halted; obs_req = Mem_Req;
    obs_ill_after = Illegal; obs_load_after = Load_Reg; obs_bus_after = Bus_Out;
    model_exec(instr, a, b);
  endtask

  task automatic apply_reset();
    Reset = 1'b0; Mem_Ready = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic load_seen, req_low, addr_bad;
    load_seen = 1'b0; req_low = 1'b0; addr_bad = 1'b0;
    Reset = 1'b0; Mem_Ready = 1'b0; Mem_Data = 16'h1261;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      if (Load_Reg !== 1'b0) load_seen = 1'b1;
      if (Mem_Req !== 1'b1) req_low = 1'b1;
      if (Mem_Addr !== 16'h3000) addr_bad = 1'b1;
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    model_reset();
    checks++; if (load_seen !== 1'b0) begin errors++; $display("FAIL reset_load: Load_Reg went high, required 0"); end
    checks++; if (req_low !== 1'b0) begin errors++; $display("FAIL reset_req: Mem_Req dropped, required 1"); end
    checks++; if (addr_bad !== 1'b0) begin errors++; $display("FAIL reset_addr: Mem_Addr %h, required 3000", Mem_Addr); end
    checks++; if (PC !== 16'h3000) begin errors++; $display("FAIL reset_pc: got %h required 3000", PC); end
    checks++; if (NZP !== 3'b010) begin errors++; $display("FAIL reset_nzp: got %b required 010", NZP); end
    checks++; if (IR !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h required 0000", IR); end
    checks++; if (Halted !== 1'b0 || Mem_Req !== 1'b1) begin errors++; $display("FAIL reset_state: Halted=%b Mem_Req=%b required 0/1", Halted, Mem_Req); end
  endtask

  task automatic test_add();
    do_instr(16'h1261, 16'h0005, 16'hBEEF, 2);
    checks++; if (obs_addr_stable !== 1'b1 || obs_fetch_addr !== 16'h3000) begin errors++; $display("FAIL add_fetch_addr: got %h required 3000 stable", obs_fetch_addr); end
    checks++; if (obs_load !== 1'b1 || obs_dr !== 3'd1) begin errors++; $display("FAIL add_load: Load_Reg=%b DR=%0d required 1/1", obs_load, obs_dr); end
    checks++; if (obs_sr1c !== 3'd1) begin errors++; $display("FAIL add_sr1: got %0d required 1", obs_sr1c); end
    checks++; if (obs_bus !== 16'h0006) begin errors++; $display("FAIL add_bus: got %h required 0006", obs_bus); end
    checks++; if (obs_nzp !== 3'b001) begin errors++; $display("FAIL add_nzp: got %b required 001", obs_nzp); end
    checks++; if (obs_pc !== 16'h3001) begin errors++; $display("FAIL add_pc: got %h required 3001", obs_pc); end
    checks++; if (obs_dec_req !== 1'b0 || obs_req !== 1'b1) begin errors++; $display("FAIL add_3cycle: req decode=%b after=%b required 0/1", obs_dec_req, obs_req); end
  endtask

  task automatic test_and_br();
    do_instr(16'h5020, 16'h1234, 16'h5678, 0);
    checks++; if (obs_bus !== 16'h0000 || obs_load !== 1'b1) begin errors++; $display("FAIL and_bus: got %h load %b required 0000 load 1", obs_bus, obs_load); end
    checks++; if (obs_nzp !== 3'b010) begin errors++; $display("FAIL and_nzp: got %b required 010", obs_nzp); end
    do_instr(16'h0402, 16'h0, 16'h0, 1);
    checks++; if (obs_pc !== m_pc || obs_load !== 1'b0) begin errors++; $display("FAIL brz_taken: pc %h load %b required %h load 0", obs_pc, obs_load, m_pc); end
    do_instr(16'h1261, 16'h0005, 16'h0, 0);
    do_instr(16'h0402, 16'h0, 16'h0, 0);
    checks++; if (obs_pc !== m_pc || obs_pc !== e_fetch_addr + 16'd1) begin errors++; $display("FAIL brz_not_taken: pc %h required %h", obs_pc, e_fetch_addr + 16'd1); end
    do_instr(16'h0005, 16'h0, 16'h0, 0);
    checks++; if (obs_pc !== e_fetch_addr + 16'd1) begin errors++; $display("FAIL br_nzp000: pc %h required %h", obs_pc, e_fetch_addr + 16'd1); end
  endtask

  task automatic test_not_lea();
    apply_reset();
    do_instr(16'hE5FF, 16'h1111, 16'h2222, 0);
    checks++; if (obs_bus !== 16'h3000 || obs_dr !== 3'd2 || obs_load !== 1'b1) begin errors++; $display("FAIL lea_bus: got %h dr %0d required 3000 dr 2", obs_bus, obs_dr); end
    checks++; if (obs_nzp !== 3'b010) begin errors++; $display("FAIL lea_nzp: got %b required 010", obs_nzp); end
    do_instr(16'h967F, 16'h0000, 16'h0, 1);
    checks++; if (obs_bus !== 16'hFFFF || obs_dr !== 3'd3 || obs_sr1c !== 3'd1) begin errors++; $display("FAIL not_bus: got %h dr %0d sr1 %0d required FFFF 3 1", obs_bus, obs_dr, obs_sr1c); end
    checks++; if (obs_nzp !== 3'b100) begin errors++; $display("FAIL not_nzp: got %b required 100", obs_nzp); end
    do_instr(16'hE5FF, 16'h0, 16'h0, 0);
    checks++; if (obs_bus !== e_bus || obs_nzp !== 3'b100) begin errors++; $display("FAIL lea_keep_nzp: bus %h nzp %b required %h 100", obs_bus, obs_nzp, e_bus); end
  endtask

  task automatic test_halt();
    logic stuck_ok;
    logic [15:0] pc_hold;
    do_instr(16'hF025, 16'h0, 16'h0, 0);
    checks++; if (obs_halt !== 1'b1 || obs_req !== 1'b0 || obs_load_after !== 1'b0) begin errors++; $display("FAIL halt_enter: halted %b req %b load %b required 1 0 0", obs_halt, obs_req, obs_load_after); end
    stuck_ok = 1'b1; pc_hold = PC;
    Mem_Ready = 1'b1; Mem_Data = 16'h1261;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      if (Halted !== 1'b1 || Mem_Req !== 1'b0 || Load_Reg !== 1'b0 || PC !== pc_hold) stuck_ok = 1'b0;
    end
    Mem_Ready = 1'b0;
    checks++; if (stuck_ok !== 1'b1) begin errors++; $display("FAIL halt_hold: left HALT or pc moved, got pc %h required %h", PC, pc_hold); end
    apply_reset();
    checks++; if (Halted !== 1'b0 || PC !== 16'h3000 || Mem_Req !== 1'b1) begin errors++; $display("FAIL halt_reset: halted %b pc %h req %b required 0 3000 1", Halted, PC, Mem_Req); end
  endtask

  task automatic test_illegal();
    do_instr(16'hD000, 16'h0, 16'h0, 0);
    checks++; if (obs_ill !== 1'b1 || obs_load !== 1'b0) begin errors++; $display("FAIL illegal_pulse: illegal %b load %b required 1 0", obs_ill, obs_load); end
    checks++; if (obs_ill_after !== 1'b0) begin errors++; $display("FAIL illegal_width: still %b next cycle, required 0", obs_ill_after); end
    do_instr(16'hF012, 16'h0, 16'h0, 0);
    checks++; if (obs_ill !== 1'b1 || obs_halt !== 1'b0) begin errors++; $display("FAIL trap_other: illegal %b halted %b required 1 0", obs_ill, obs_halt); end
    do_instr(16'h1261, 16'h0001, 16'h0, 0);
    checks++; if (obs_fetch_addr !== 16'h3002) begin errors++; $display("FAIL illegal_next_pc: fetch addr %h required 3002", obs_fetch_addr); end
  endtask

  task automatic test_reset_midfetch();
    do_instr(16'h1261, 16'h0007, 16'h0, 0);
    Mem_Ready = 1'b1; Mem_Data = 16'h1261; Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1; Mem_Ready = 1'b0;
    model_reset();
    checks++; if (IR !== 16'h0000 || PC !== 16'h3000 || Mem_Req !== 1'b1) begin errors++; $display("FAIL reset_midfetch: IR %h PC %h req %b required 0000 3000 1", IR, PC, Mem_Req); end
  endtask

  task automatic test_wrap();
    int d, step, off;
    logic [8:0] off9;
    apply_reset();
    for (int n = 0; n < 100 && m_pc != 16'hFFFF; n++) begin
      d = int'(m_pc) + 1;
      step = (d > 255) ? 255 : d;
      off = -step - 1;
      off9 = 9'(off);
      do_instr({4'b0000, 3'b111, off9}, 16'h0, 16'h0, 0);
    end
    checks++; if (PC !== 16'hFFFF) begin errors++; $display("FAIL wrap_reach: pc %h required FFFF", PC); end
    do_instr(16'h1261, 16'h0001, 16'h0, 1);
    checks++; if (obs_fetch_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr: got %h required FFFF", obs_fetch_addr); end
    checks++; if (obs_pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h required 0000", obs_pc); end
  endtask

  task automatic test_random();
    logic [15:0] instr;
    logic [3:0]  bad_ops [10] = '{4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD};
    apply_reset();
    for (int n = 0; n < 80; n++) begin
      instr = 16'($urandom);
      case ($urandom_range(0, 7))
        0: instr[15:12] = 4'h1;
        1: instr[15:12] = 4'h5;
        2: instr[15:12] = 4'h9;
        3: instr[15:12] = 4'hE;
        4, 5: instr[15:12] = 4'h0;
        6: instr[15:12] = bad_ops[$urandom_range(0, 9)];
        default: begin
          instr[15:12] = 4'hF;
          if (instr[7:0] == 8'h25) instr[7:0] = 8'h26;
        end
      endcase
      do_instr(instr, 16'($urandom), 16'($urandom), $urandom_range(0, 3));
      checks++; if (obs_fetch_addr !== e_fetch_addr || obs_addr_stable !== 1'b1) begin errors++; $display("FAIL rand_addr[%0d]: got %h required %h", n, obs_fetch_addr, e_fetch_addr); end
      checks++; if (obs_load !== e_load) begin errors++; $display("FAIL rand_load[%0d] ir=%h: got %b required %b", n, instr, obs_load, e_load); end
      if (e_load) begin
        checks++; if (obs_bus !== e_bus || obs_dr !== e_dr) begin errors++; $display("FAIL rand_bus[%0d] ir=%h: got %h/%0d required %h/%0d", n, instr, obs_bus, obs_dr, e_bus, e_dr); end
      end
      checks++; if (obs_sr1c !== instr[8:6] || obs_sr2c !== instr[2:0]) begin errors++; $display("FAIL rand_srsel[%0d]: got %0d/%0d required %0d/%0d", n, obs_sr1c, obs_sr2c, instr[8:6], instr[2:0]); end
      checks++; if (obs_ill !== e_ill) begin errors++; $display("FAIL rand_illegal[%0d] ir=%h: got %b required %b", n, instr, obs_ill, e_ill); end
      checks++; if (obs_pc !== m_pc) begin errors++; $display("FAIL rand_pc[%0d] ir=%h: got %h required %h", n, instr, obs_pc, m_pc); end
      checks++; if (obs_nzp !== m_nzp) begin errors++; $display("FAIL rand_nzp[%0d] ir=%h: got %b required %b", n, instr, obs_nzp, m_nzp); end
      checks++; if (obs_halt !== m_halted || obs_req !== 1'b1) begin errors++; $display("FAIL rand_flow[%0d]: halted %b req %b required %b 1", n, obs_halt, obs_req, m_halted); end
      checks++; if (obs_dec_load !== 1'b0 || obs_load_after !== 1'b0 || obs_bus_after !== 16'h0 || obs_ill_after !== 1'b0) begin errors++; $display("FAIL rand_idle_outputs[%0d]: load %b/%b bus %h ill %b required 0", n, obs_dec_load, obs_load_after, obs_bus_after, obs_ill_after); end
    end
  endtask

  initial begin
    Reset = 1'b0; Mem_Ready = 1'b0; Mem_Data = 16'h0; SR1_Data = 16'h0; SR2_Data = 16'h0;
    model_reset();
    @(posedge Clk); #1;
    test_reset();
    test_add();
    test_and_br();
    test_not_lea();
    test_halt();
    test_illegal();
    test_reset_midfetch();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
